// File: rtl/gf_pow_sbox_engine_pkg.sv
// Shared types and default constants for the GF(2^N) power-map S-box engine.
// Imported by the multiplier and the engine top.
package gf_pow_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] POLY4_DEFAULT       = 5'b10011;      // x^4+x+1
  localparam logic [5:0] POLY5_DEFAULT       = 6'b100101;     // x^5+x^2+1
  localparam logic [6:0] POLY6_DEFAULT       = 7'b1000011;    // x^6+x+1
  localparam logic [8:0] POLY8_DEFAULT       = 9'b100011011;  // x^8+x^4+x^3+x+1
  localparam logic [5:0] AFFINE_MASK_DEFAULT = 6'b010100;

endpackage

// File: rtl/gf_pow_sbox_engine_if.sv
// Operand/result stream bundle for gf_pow_sbox_engine.
// The engine takes the slave side; the producer/consumer takes the master side.
interface gf_pow_sbox_engine_if #(
    parameter int N = 6
) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_x;
    logic [N-1:0] in_e;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_y;
    logic         busy;

    modport slave (
        input  in_valid, in_x, in_e, out_ready,
        output in_ready, out_valid, out_y, busy
    );

    modport master (
        output in_valid, in_x, in_e, out_ready,
        input  in_ready, out_valid, out_y, busy
    );
endinterface

// File: rtl/gf_pow_sbox_engine_gf_mul.sv
// Combinational polynomial-basis multiplier over GF(2^N): p = a*b mod POLY.
// Shift-and-add with the reduction folded into each shift of a.
module gf_mul
    import gf_pow_pkg::*;
#(
    parameter int         N    = 6,
    parameter logic [N:0] POLY = POLY6_DEFAULT
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] p
);

    logic [N-1:0] shifted;

    always_comb begin
        // NOTE: every variable gets a default before the loop, so no path leaves one unassigned (no latch).
        p       = '0;
        shifted = a;
        for (int i = 0; i < N; i++) begin
            if (b[i]) p = p ^ shifted;
            shifted = shifted[N-1] ? ((shifted << 1) ^ POLY[N-1:0]) : (shifted << 1);
        end
    end

endmodule

// File: rtl/gf_pow_sbox_engine.sv
// Iterative y = x^E engine over GF(2^N), MSB-first square-and-multiply, one exponent bit per cycle.
// Optional broadcast-parity output addition enabled by macro GF_POW_AFFINE_EN.
module gf_pow_sbox_engine
    import gf_pow_pkg::*;
#(
    parameter int N           = 6,
    parameter     POLY        = POLY6_DEFAULT,
    parameter     AFFINE_MASK = AFFINE_MASK_DEFAULT
) (
    input logic                   clk,
    input logic                   rst_n,
    gf_pow_sbox_engine_if.slave   bus
);

    localparam int KW = (N > 1) ? $clog2(N) : 1;

    if (N < 2 || N > 16 || $bits(POLY) != N + 1 || $bits(AFFINE_MASK) != N) begin : g_bad_params
        $error("gf_pow_sbox_engine: N must be 2..16, POLY N+1 bits, AFFINE_MASK N bits");
    end

    state_t       state;
    logic [KW-1:0] k;
    logic [N-1:0] x_q;
    logic [N-1:0] e_q;
    logic [N-1:0] acc;
    logic [N-1:0] acc_sq;
    logic [N-1:0] acc_mx;
    logic [N-1:0] acc_next;
    logic [N-1:0] out_mask;

    gf_mul #(.N(N), .POLY(POLY)) u_square (
        .a (acc),
        .b (acc),
        .p (acc_sq)
    );

    gf_mul #(.N(N), .POLY(POLY)) u_mul_x (
        .a (acc_sq),
        .b (x_q),
        .p (acc_mx)
    );

    assign acc_next = e_q[k] ? acc_mx : acc_sq;

`ifdef GF_POW_AFFINE_EN
    assign out_mask = {N{^(x_q & AFFINE_MASK)}};
`else
    assign out_mask = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset along with the FSM so out_y/acc read 0 and no X reaches the multipliers.
            state         <= IDLE;
            k             <= '0;
            x_q           <= '0;
            e_q           <= '0;
            acc           <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_y     <= '0;
            bus.busy      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments: every register samples pre-edge values, so acc/k/state update together.
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_q          <= bus.in_x;
                        e_q          <= bus.in_e;
                        acc          <= {{(N-1){1'b0}}, 1'b1};
                        k            <= KW'(N - 1);
                        state        <= RUN;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                    end
                end

                RUN: begin
                    acc <= acc_next;
                    if (k == '0) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.out_y     <= acc_next ^ out_mask;
`ifndef GF_POW_AFFINE_EN
                        x_q           <= '0;
`endif
                    end else begin
                        k <= k - 1'b1;
                    end
                end

                DONE: begin
                    // Result register holds out_y steady for as long as the consumer stalls.
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b0;
                    end
                end

                default: begin
                    state         <= IDLE;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/gf_pow_sbox_engine.md
# gf_pow_sbox_engine

Iterative power-map S-box engine over GF(2^N) in polynomial basis. Computes y = x^E with a runtime exponent, then applies the broadcast-parity output addition. It is the parametrised, multi-cycle successor of the fixed-exponent, fixed-width combinational S-boxes. It sits behind a valid/ready stream, so one datapath serves any exponent and field width.

## Interface
Parameters:
- N, 6, field width in bits (2..16).
- POLY, 7'b1000011, irreducible polynomial, N+1 bits, MSB is x^N (default x^6+x+1).
- AFFINE_MASK, 6'b010100, N bits; bits of x whose XOR is broadcast onto the result.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- in_valid  in  1  operand valid.
- in_ready  out  1  engine can accept an operand.
- in_x  in  N  field element x.
- in_e  in  N  exponent E, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_y  out  N  result.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states:
  - IDLE: in_ready=1. Transfer when in_valid&&in_ready; latch x and E; set acc=1 and bit index k=N-1; go to RUN.
  - RUN: each cycle, acc ← acc² · (E[k] ? x : 1) mod POLY, then k decrements. After k=0 is processed, go to DONE.
  - DONE: out_valid=1 and out_y is held stable. Transfer when out_valid&&out_ready; go to IDLE.
- Arithmetic is carry-less multiply with reduction by POLY, all N bits wide. Square and conditional multiply happen in the same cycle.
- Exponent rules:
  - E=0 gives 1 for every x, including x=0.
  - x=0 with E≠0 gives 0.
  - E is not reduced mod 2^N−1, so E=2^N−1 with x≠0 gives 1.
- Output addition (when enabled): out_y = acc XOR {N{^(x & AFFINE_MASK)}}, using the latched x.
- No bypass path: a result transfer and a new accept never happen in the same cycle.
- in_x and in_e are ignored outside the IDLE transfer cycle.

## Timing
- Reset (rst_n=0 at a clk edge) gives: state IDLE, in_ready=1, out_valid=0, busy=0, out_y=0, acc=0.
- Reset mid-RUN or mid-DONE discards the operation and no result is emitted.
- Latency: accept at edge 0; RUN covers edges 1..N; out_valid is high starting the cycle after edge N, so out_valid rises N edges after the accept.
- in_ready falls the cycle after the accept. It rises again the cycle after the out transfer.
- Back-to-back throughput is one result per N+2 cycles with out_ready held high.
- out_ready low in DONE stalls indefinitely. out_y and out_valid stay constant during the stall.
- out_ready asserted outside DONE has no effect.

## Configuration
- Macro GF_POW_AFFINE_EN.
  - Defined: the output addition with AFFINE_MASK is applied.
  - Undefined: out_y = acc, AFFINE_MASK is unused, and latched x is not kept after RUN.
- Latency and handshake are identical in both builds.

## Structure
- Package gf_pow_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - default POLY constants for N=4, 5, 6, 8;
  - the AFFINE_MASK default.
- Sub-module gf_mul: combinational polynomial-basis multiplier with parameters N and POLY. It is instantiated twice, once for squaring acc and once for multiplying by x.
- The engine holds only the FSM, the counter k, and the x, E and acc registers.

## Test plan
All cases use N=6 and POLY=x^6+x+1. Values marked "affine" are for the GF_POW_AFFINE_EN build.
- x=0x02, E=0x06: out_y=0x03, with or without affine, since mask parity of x is 0. out_valid rises 6 edges after accept.
- x=0x04, E=0x01, affine: out_y=0x3B. Without affine: out_y=0x04.
- x=0x00, E=0x00: out_y=0x01 without affine. x=0x00, E=0x1A: out_y=0x00.
- x=0x02, E=0x3F: out_y=0x01. Back-to-back x=0x02, E=0x3F with out_ready high: results arrive 8 cycles apart and in_ready is low while busy.
- Hold out_ready=0 for 5 cycles in DONE: out_y is stable and in_ready stays 0. Then pulse out_ready: one transfer, and in_ready=1 next cycle.
- Assert rst_n=0 at RUN cycle 3: all outputs return to reset values at the next edge and no out_valid pulse occurs. Random sweep: all 64×64 (x, E) pairs compared against a software GF model.
